// File: rtl/vdp_pkg.sv
// Shared text-mode constants, fetch FSM encoding and the Apple II row-interleave helper.
// Pure declarations; no timing or flow control of its own.
package vdp_pkg;

  localparam int          TXT_COLS       = 40;
  localparam int          TXT_ROWS       = 24;
  localparam logic [7:0]  TXT_BLANK_CHAR = 8'hA0;
  localparam logic [15:0] TXT_BASE       = 16'h0400;
  localparam logic [15:0] TXT_PAGE2_OFS  = 16'h0400;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_BLANK,
    ST_SWAP
  } fetch_state_e;

  // Rows interleave in groups of eight: low bits pick a 128-byte slot, high bits a 40-byte third.
  function automatic logic [15:0] row_base(input logic [4:0] row);
    return {6'b0, row[2:0], 7'b0} + (16'(row[4:3]) * 16'd40);
  endfunction

endpackage

// File: rtl/line_buf.sv
// Double-banked 2x64x8 character line buffer: writes go to the back bank, reads come from the front.
// Read data registered, 1-cycle latency; no backpressure (one write and one read every cycle).
module line_buf
  import vdp_pkg::*;
#(
  parameter int         COLS       = TXT_COLS,
  parameter logic [7:0] BLANK_CHAR = TXT_BLANK_CHAR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [5:0] wr_col,
  input  logic [7:0] wr_dat,
  input  logic       swap,
  input  logic       front_valid,
  input  logic [5:0] rd_col,
  output logic [7:0] rd_char
);

  localparam logic [6:0] COLS7 = 7'(COLS);

  logic [7:0] ram [2][64];
  logic       bank_q, bank_d;
  logic [7:0] rd_char_q, rd_char_d;

  always_comb begin
    bank_d    = swap ? ~bank_q : bank_q;
    rd_char_d = ram[bank_q][rd_col];
    if (!front_valid || ({1'b0, rd_col} >= COLS7)) begin
      rd_char_d = BLANK_CHAR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q    <= 1'b0;
      rd_char_q <= BLANK_CHAR;
    end else begin
      bank_q    <= bank_d;
      rd_char_q <= rd_char_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[~bank_q][wr_col] <= wr_dat;
    end
  end

  assign rd_char = rd_char_q;

endmodule

// File: rtl/text_row_fetch.sv
// Fetches one 40-column text row into the back bank of a line buffer, then swaps banks and acks.
// One read outstanding; stalls in ISSUE until granted, row costs COLS*(1+MEM_LAT)+2 cycles unstalled.
module text_row_fetch
  import vdp_pkg::*;
#(
  parameter logic [15:0] BASE       = TXT_BASE,
  parameter logic [15:0] PAGE2_OFS  = TXT_PAGE2_OFS,
  parameter int          COLS       = TXT_COLS,
  parameter int          ROWS       = TXT_ROWS,
  parameter int          MEM_LAT    = 1,
  parameter logic [7:0]  BLANK_CHAR = TXT_BLANK_CHAR
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        page2,
  input  logic        row_req,
  input  logic [4:0]  row,
  output logic        row_ack,
  output logic [4:0]  cur_row,
  input  logic [5:0]  rd_col,
  output logic [7:0]  rd_char,
  output logic [15:0] mem_adr,
  output logic        mem_rd,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_q
);

  localparam int            LW       = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);
  localparam logic [LW-1:0] LAT_INIT = LW'(MEM_LAT);
  localparam logic [5:0]    LAST_COL = 6'(COLS - 1);
  localparam logic [5:0]    ROWS6    = 6'(ROWS);

  fetch_state_e  state_q, state_d;
  logic [4:0]    row_q, row_d;
  logic          page2_q, page2_d;
  logic [5:0]    col_q, col_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          mem_rd_q, mem_rd_d;
  logic          row_ack_q, row_ack_d;
  logic [4:0]    cur_row_q, cur_row_d;
  logic          front_valid_q, front_valid_d;
  logic          wr_en, swap;
  logic [7:0]    wr_dat;

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    page2_d       = page2_q;
    col_d         = col_q;
    lat_d         = lat_q;
    mem_rd_d      = mem_rd_q;
    row_ack_d     = 1'b0;
    cur_row_d     = cur_row_q;
    front_valid_d = front_valid_q;
    wr_en         = 1'b0;
    wr_dat        = mem_q;
    swap          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (row_req) begin
          row_d   = row;
          page2_d = page2;
          col_d   = 6'd0;
          if ({1'b0, row} >= ROWS6) begin
            state_d = ST_BLANK;
          end else begin
            state_d  = ST_ISSUE;
            mem_rd_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        // A grant in the same cycle as a dropped request still commits that read.
        if (mem_gnt) begin
          mem_rd_d = 1'b0;
          lat_d    = LAT_INIT;
          state_d  = ST_WAIT;
        end else if (!row_req) begin
          mem_rd_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_q != LW'(1)) begin
          lat_d = lat_q - LW'(1);
        end else begin
          wr_en = 1'b1;
          if (!row_req) begin
            state_d = ST_IDLE;
          end else if (col_q == LAST_COL) begin
            state_d = ST_SWAP;
          end else begin
            col_d    = col_q + 6'd1;
            mem_rd_d = 1'b1;
            state_d  = ST_ISSUE;
          end
        end
      end
      ST_BLANK: begin
        wr_en  = 1'b1;
        wr_dat = BLANK_CHAR;
        if (!row_req) begin
          state_d = ST_IDLE;
        end else if (col_q == LAST_COL) begin
          state_d = ST_SWAP;
        end else begin
          col_d = col_q + 6'd1;
        end
      end
      ST_SWAP: begin
        swap          = 1'b1;
        front_valid_d = 1'b1;
        cur_row_d     = row_q;
        row_ack_d     = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      row_q         <= 5'd0;
      page2_q       <= 1'b0;
      col_q         <= 6'd0;
      lat_q         <= '0;
      mem_rd_q      <= 1'b0;
      row_ack_q     <= 1'b0;
      cur_row_q     <= 5'd0;
      front_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      page2_q       <= page2_d;
      col_q         <= col_d;
      lat_q         <= lat_d;
      mem_rd_q      <= mem_rd_d;
      row_ack_q     <= row_ack_d;
      cur_row_q     <= cur_row_d;
      front_valid_q <= front_valid_d;
    end
  end

  line_buf #(
    .COLS       (COLS),
    .BLANK_CHAR (BLANK_CHAR)
  ) u_line_buf (
    .clk         (CLOCK_50),
    .rst_n       (reset),
    .wr_en       (wr_en),
    .wr_col      (col_q),
    .wr_dat      (wr_dat),
    .swap        (swap),
    .front_valid (front_valid_q),
    .rd_col      (rd_col),
    .rd_char     (rd_char)
  );

  assign mem_adr = mem_rd_q ? (BASE + (page2_q ? PAGE2_OFS : 16'h0000) + row_base(row_q)
                               + {10'b0, col_q}) : 16'h0000;
  assign mem_rd  = mem_rd_q;
  assign row_ack = row_ack_q;
  assign cur_row = cur_row_q;

endmodule

// File: doc/text_row_fetch.md
Name: text_row_fetch

Overview:
- Upstream stage of the character renderer. Fetches one 40-character Apple II text row from main memory into a double-buffered line buffer, decoding the interleaved $400/$800 page layout.
- The renderer reads character codes from the front bank while the next row fills the back bank.
- Memory access goes through a request/grant slot that is shared with the CPU.

Parameters:
- BASE, 16'h0400: page-1 text base address.
- PAGE2_OFS, 16'h0400: offset added when page2=1, giving $800.
- COLS, 40: characters per row.
- ROWS, 24: valid text rows.
- MEM_LAT, 1: cycles from an accepted read (mem_rd&mem_gnt) to mem_q valid; must be ≥1.
- BLANK_CHAR, 8'hA0: code substituted for out-of-range or never-loaded data.

Ports:
- CLOCK_50  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- page2  in  1  text page select, sampled at request acceptance.
- row_req  in  1  renderer requests a row load; held until row_ack or deliberately dropped.
- row  in  5  text row 0..31; 24..31 are blank rows.
- row_ack  out  1  one-cycle pulse: row loaded and banks swapped.
- cur_row  out  5  row held in the front bank.
- rd_col  in  6  front-bank column to read.
- rd_char  out  8  character at rd_col, registered, 1-cycle latency.
- mem_adr  out  16  read address.
- mem_rd  out  1  read request.
- mem_gnt  in  1  bus slot granted this cycle.
- mem_q  in  8  read data, valid MEM_LAT cycles after acceptance.

Behaviour:
- Reset values: all outputs 0 except rd_char, which is BLANK_CHAR. State=IDLE, front bank = 0, front_valid = 0.
- While front_valid=0, rd_char = BLANK_CHAR.
- Address:
  - mem_adr = BASE + (page2 ? PAGE2_OFS : 0) + {row[2:0],7'b0} + row[4:3]*40 + col.
  - Arithmetic is 16-bit; carry out is discarded.
  - Checkpoints: row0 col0 → $0400; row8 col0 → $0428; row16 col0 → $0450; row23 col39 → $07F7.
- FSM states:
  - IDLE: if row_req, latch row and page2, set col=0, go to ISSUE (or to BLANK if row ≥ ROWS).
  - ISSUE: mem_rd=1, mem_adr valid. Stay until mem_gnt=1. On grant, deassert mem_rd next cycle, load lat_cnt=MEM_LAT, go to WAIT.
  - WAIT: decrement lat_cnt. When it expires, write mem_q into back[col] in that cycle. If col==COLS-1 go to SWAP, else col++ and go to ISSUE.
  - BLANK: write BLANK_CHAR into back[col], one per cycle, with no bus traffic. After col COLS-1, go to SWAP.
  - SWAP: toggle the front/back select, set front_valid=1, cur_row=latched row, row_ack=1 for one cycle, go to IDLE.
- Only one read is outstanding at a time. A normal row costs COLS×(1+MEM_LAT)+2 cycles with no grant stalls (82 at defaults).
- Read port:
  - rd_char = front[rd_col] on the next clock.
  - rd_col ≥ COLS returns BLANK_CHAR.
  - A read in the cycle of SWAP returns the old front bank; the cycle after returns the new one.
- Abort: if row_req drops during ISSUE (before a grant), go to IDLE immediately. mem_rd deasserts the next cycle; no swap, no ack.
- If row_req drops during WAIT or BLANK, finish the current column write, then go to IDLE with no swap.
- row_req held high after ack: a new fetch starts from IDLE on the following cycle, reloading the same row if row is unchanged.
- Changing row or page2 while a fetch is in progress has no effect; both are latched at acceptance.
- mem_gnt while mem_rd=0 is ignored.
- Asynchronous reset mid-fetch aborts immediately: mem_rd drops, front_valid clears, no ack is issued.

Decomposition:
- Shared package vdp_pkg holds TXT_COLS=40, TXT_ROWS=24, BLANK_CHAR, TXT_BASE, the fetch state enum and the row-base function (row → offset).
- Sub-module line_buf: 2×64×8 RAM with one write port and one registered read port, plus bank select. Instantiated once.

Test Plan:
- Reset, then read rd_col=0..39 before any request → rd_char=8'hA0 for every column; cur_row=0; row_ack never pulses.
- Memory model returns (addr[7:0]), MEM_LAT=1, gnt held at 1; request row=9, page2=0 → addresses $04A8..$04CF in order; row_ack after 82 cycles; rd_col=5 → 8'hAD; cur_row=9.
- page2=1, row=23 → first address $0BD0, last $0BF7; rd_col=39 → 8'hF7.
- Gnt stalls: mem_gnt random at 30% duty, MEM_LAT=3 → mem_rd held stable until each grant; exactly 40 accepted reads; buffer contents correct.
- row=26 → no mem_rd assertion; ack after 42 cycles; all 40 columns read 8'hA0; rd_col=50 → 8'hA0.
- Abort and reset: drop row_req at column 20 → no ack, front bank still holds the prior row. Assert reset mid-fetch → mem_rd=0 in the same cycle; rd_char=8'hA0 after reset is released.
